// File: rtl/cond_exec_ctrl.sv
`timescale 1ns/1ps
// ARM-style conditional-execution sequencer in front of the ALU; owns the N/Z/C/V flag register.
// Define COND_PERF_CNT_EN to add saturating exec_cnt/skip_cnt performance counters.
module cond_exec_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic        in_s,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_exec,
  output logic        err_timeout,
`ifdef COND_PERF_CNT_EN
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt,
`endif
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {StIdle, StEval, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cond_q, cond_d;
  logic        s_q, s_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        exec_q, exec_d;
  logic        to_q, to_d;
  logic [3:0]  flags_q, flags_d;
  logic        cond_pass;

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    unique case (cond_q)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cond_d   = cond_q;
    s_d      = s_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    exec_d   = exec_q;
    to_d     = to_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cond_d  = in_cond;
          s_d     = in_s;
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          state_d = StEval;
        end
      end
      StEval: begin
        if (cond_pass) begin
          state_d = StIssue;
        end else begin
          exec_d   = 1'b0;
          result_d = '0;
          to_d     = 1'b0;
          state_d  = StResp;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        // A done arriving on the last allowed cycle still counts as a completion.
        if (alu_done) begin
          result_d = alu_result;
          exec_d   = 1'b1;
          to_d     = 1'b0;
          if (s_q) flags_d = alu_flags;
          state_d  = StResp;
        end else if (cnt_q == TimeoutLast) begin
          result_d = '0;
          exec_d   = 1'b1;
          to_d     = 1'b1;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (out_ready) begin
          to_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cond_q   <= '0;
      s_q      <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exec_q   <= 1'b0;
      to_q     <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cond_q   <= cond_d;
      s_q      <= s_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      exec_q   <= exec_d;
      to_q     <= to_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign alu_start   = (state_q == StIssue);
  assign out_valid   = (state_q == StResp);
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign out_result  = result_q;
  assign out_exec    = exec_q;
  assign err_timeout = to_q;
  assign flags       = flags_q;

`ifdef COND_PERF_CNT_EN
  logic             resp_hs;
  logic [CNT_W-1:0] exec_cnt_q, skip_cnt_q;

  assign resp_hs = (state_q == StResp) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else if (resp_hs) begin
      if (exec_q && !to_q && (exec_cnt_q != '1)) exec_cnt_q <= exec_cnt_q + CNT_W'(1);
      if (!exec_q && (skip_cnt_q != '1)) skip_cnt_q <= skip_cnt_q + CNT_W'(1);
    end
  end

  assign exec_cnt = exec_cnt_q;
  assign skip_cnt = skip_cnt_q;
`else
  logic [CNT_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule
